text_pixel_pipeline: RTL and testbench
======================================

// Module: text_pixel_pipeline
// PURPOSE
// - Pipelined, parametrised text-mode pixel generator. Sits between the VGA timing generator / VRAM fetch and the HDMI encoder.
// - Maps a character cell (glyph, invert, fg/bg palette index, blink) plus the DrawX/DrawY scan position to registered RGB.
// - Reads a synchronous font ROM (1-cycle read). Holds a writable colour palette and a frame-based blink timer.
// PARAMETERS
// - COLOR_W       4   bits per colour channel
// - PAL_DEPTH     16  palette entries (power of 2); PW = $clog2(PAL_DEPTH)
// - GLYPH_W       8   glyph width in pixels (power of 2)
// - FONT_H        16  glyph height in rows (power of 2)
// - BLINK_FRAMES  32  frames per blink half-period (>=1)
// PORTS
// - pixel_clk   in   1            pixel clock
// - reset       in   1            asynchronous, active-high reset
// - DrawX       in   10           current pixel column
// - DrawY       in   10           current pixel row
// - vde         in   1            active-video qualifier for DrawX/DrawY
// - frame_start in   1            one-cycle pulse at start of each frame
// - glyph       in   8            [6:0] glyph code; [7] invert
// - fg_idx      in   PW           foreground palette index
// - bg_idx      in   PW           background palette index
// - blink       in   1            cell blinks with the blink phase
// - font_addr   out  7+log2(FONT_H)  font ROM address (registered)
// - font_data   in   GLYPH_W      font ROM row; valid 1 cycle after font_addr; MSB = leftmost pixel
// - pal_we      in   1            palette write strobe
// - pal_waddr   in   PW           palette write index
// - pal_wdata   in   3*COLOR_W    {R,G,B} palette entry
// - cursor_col  in   7            cursor cell column
// - cursor_row  in   6            cursor cell row
// - Red/Green/Blue  out  COLOR_W  registered pixel colour
// - vde_out     out  1            vde delayed to match RGB
// BEHAVIOUR
// - Latency: fixed 3 pixel_clk cycles from inputs to RGB/vde_out. One pixel accepted every cycle, no stalls.
// - S1 (edge N+1): font_addr = glyph[6:0]*FONT_H + DrawY[log2(FONT_H)-1:0].
//   Register col = DrawX mod GLYPH_W, invert, fg_idx, bg_idx, blink, vde, cursor-hit.
// - S2 (edge N+2): ROM presents font_data. Register bit = font_data[GLYPH_W-1-col] and the attributes.
// - S3 (edge N+3): on = bit XOR invert. If blink && blink_phase, on = 0.
//   Output colour = palette[on ? fg_idx : bg_idx]. If the delayed vde = 0, RGB = 0.
// - Palette: PAL_DEPTH x 3*COLOR_W registers.
//   - On pal_we, pal_waddr is written at the edge.
//   - A same-cycle lookup of the same entry returns the old value; the new value is used from the next cycle.
// - Blink timer: frame counter of width $clog2(BLINK_FRAMES), plus blink_phase.
//   - On frame_start: if counter == BLINK_FRAMES-1, counter wraps to 0 and blink_phase toggles; else counter increments.
//   - With BLINK_FRAMES=1, blink_phase toggles every frame_start.
//   - The phase is sampled at S3, so a toggle affects pixels reaching S3 after the edge.
// - Reset (async, any time, mid-line included):
//   - All pipeline registers cleared; RGB=0, vde_out=0, font_addr=0.
//   - Counter=0, blink_phase=0 (visible).
//   - Palette: entry 0 = 0 (black); all other entries = all-ones (white).
//   - After deassertion, the first valid output appears 3 cycles after the first vde=1 input.
// - DrawX/DrawY are not range-checked; only the low bits are used. Glyph codes wrap within 128.
// CONFIGURATION
// - TEXT_PIXEL_CURSOR_EN defined: cursor-hit = (DrawX/GLYPH_W == cursor_col) && (DrawY/FONT_H == cursor_row)
//   && (DrawY mod FONT_H >= FONT_H-2).
//   - A hit inverts `on` (fg/bg swap) after the blink gating.
//   - The cursor itself is shown only when blink_phase = 0.
// - TEXT_PIXEL_CURSOR_EN undefined: cursor ports are present but ignored; cursor-hit is tied 0. Same latency.
// TESTING
// - Reset: assert reset mid-line -> RGB=0, vde_out=0 immediately.
//   After release, palette[0]=000, palette[5]=FFF (readback via render).
// - Latency/bit order: glyph=0x41, row 3, font_data=8'b1000_0000, fg=1, bg=0, DrawX=0..7, vde=1
//   -> RGB=FFF at x=0 only, 000 at x=1..7, each 3 cycles after input.
// - Invert: glyph=0xC1, same font row -> x=0 black, x=1..7 white.
//   vde=0 for any input -> RGB=000.
// - Palette: write pal_waddr=3, pal_wdata=12'hF00, same cycle as a fg_idx=3 lookup at S3 -> old FFF.
//   Next pixel -> F00.
// - Blink: BLINK_FRAMES=2, blink=1 cell -> fg shown frames 0-1, bg frames 2-3, fg again at frame 4.
//   blink=0 cells unchanged throughout.
// - Cursor (EN build): cursor_col=2, cursor_row=1, DrawY=30, DrawX=16..23, blank glyph
//   -> fg colour while phase 0, bg while phase 1; DrawY=29 -> bg. Non-EN build -> always bg.

Source files
------------

// File: rtl/text_pixel_pipeline_if.sv
// Pixel-side bundle of the text pixel pipeline: scan position, cell attributes,
// font ROM port, palette write port, cursor position and RGB result.
interface text_pixel_pipeline_if #(
  parameter int COLOR_W   = 4,
  parameter int PAL_DEPTH = 16,
  parameter int GLYPH_W   = 8,
  parameter int FONT_H    = 16
);
  localparam int PW   = $clog2(PAL_DEPTH);
  localparam int FA_W = 7 + $clog2(FONT_H);

  logic [9:0]           DrawX;
  logic [9:0]           DrawY;
  logic                 vde;
  logic                 frame_start;
  logic [7:0]           glyph;
  logic [PW-1:0]        fg_idx;
  logic [PW-1:0]        bg_idx;
  logic                 blink;
  logic [FA_W-1:0]      font_addr;
  logic [GLYPH_W-1:0]   font_data;
  logic                 pal_we;
  logic [PW-1:0]        pal_waddr;
  logic [3*COLOR_W-1:0] pal_wdata;
  logic [6:0]           cursor_col;
  logic [5:0]           cursor_row;
  logic [COLOR_W-1:0]   Red;
  logic [COLOR_W-1:0]   Green;
  logic [COLOR_W-1:0]   Blue;
  logic                 vde_out;

  // master: timing generator / VRAM fetch / font ROM side
  modport master (
    output DrawX, DrawY, vde, frame_start, glyph, fg_idx, bg_idx, blink,
    output font_data, pal_we, pal_waddr, pal_wdata, cursor_col, cursor_row,
    input  font_addr, Red, Green, Blue, vde_out
  );

  modport slave (
    input  DrawX, DrawY, vde, frame_start, glyph, fg_idx, bg_idx, blink,
    input  font_data, pal_we, pal_waddr, pal_wdata, cursor_col, cursor_row,
    output font_addr, Red, Green, Blue, vde_out
  );
endinterface

// File: rtl/text_pixel_pipeline.sv
// Three-stage text-mode pixel generator: font ROM address, glyph bit pick, palette lookup.
// Define TEXT_PIXEL_CURSOR_EN to overlay a blinking underline cursor on the bottom two glyph rows.
module text_pixel_pipeline #(
  parameter int COLOR_W      = 4,
  parameter int PAL_DEPTH    = 16,
  parameter int GLYPH_W      = 8,
  parameter int FONT_H       = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  pixel_clk,
  input  logic                  reset,
  text_pixel_pipeline_if.slave  bus
);
  localparam int PW     = $clog2(PAL_DEPTH);
  localparam int CB     = $clog2(GLYPH_W);
  localparam int RB     = $clog2(FONT_H);
  localparam int FA_W   = 7 + RB;
  localparam int RGB_W  = 3 * COLOR_W;
  localparam int BC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [CB-1:0] col;
    logic          inv;
    logic [PW-1:0] fg;
    logic [PW-1:0] bg;
    logic          blink;
    logic          cur;
  } attr_t;

  logic [FA_W-1:0]   font_addr_q, font_addr_d;
  attr_t             s1_q, s1_d, s2_q, s2_d;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic [RGB_W-1:0]  pal_q [PAL_DEPTH];
  logic [RGB_W-1:0]  pal_d [PAL_DEPTH];
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic              cur_hit;
  logic              pix_bit;
  logic              pix_on;

`ifdef TEXT_PIXEL_CURSOR_EN
  always_comb begin
    cur_hit = (10'(bus.DrawX >> CB) == 10'(bus.cursor_col)) &&
              (10'(bus.DrawY >> RB) == 10'(bus.cursor_row)) &&
              (bus.DrawY[RB-1:0] >= RB'(FONT_H - 2));
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{bus.cursor_col, bus.cursor_row, bus.DrawX[9:CB], bus.DrawY[9:RB]};
  assign cur_hit = 1'b0;
`endif

  always_comb begin
    // FONT_H is a power of two, so glyph*FONT_H + row is a plain concatenation
    font_addr_d = {bus.glyph[6:0], bus.DrawY[RB-1:0]};
    s1_d.col    = bus.DrawX[CB-1:0];
    s1_d.inv    = bus.glyph[7];
    s1_d.fg     = bus.fg_idx;
    s1_d.bg     = bus.bg_idx;
    s1_d.blink  = bus.blink;
    s1_d.cur    = cur_hit;
    s2_d        = s1_q;
    vld_pipe_d  = {vld_pipe_q[STAGES-1:1], bus.vde};
  end

  // font_data was clocked out of the ROM on the same edge that loaded s2_q;
  // MSB is leftmost, and ~col == GLYPH_W-1-col for a power-of-two width
  always_comb begin
    pix_bit = bus.font_data[~s2_q.col];
    pix_on  = pix_bit ^ s2_q.inv;
    if (s2_q.blink && phase_q) pix_on = 1'b0;
    if (s2_q.cur && !phase_q)  pix_on = ~pix_on;
    rgb_d = vld_pipe_q[2] ? pal_q[pix_on ? s2_q.fg : s2_q.bg] : '0;
  end

  always_comb begin
    pal_d = pal_q;
    if (bus.pal_we) pal_d[bus.pal_waddr] = bus.pal_wdata;
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (bus.frame_start) begin
      if (bcnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      font_addr_q <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      vld_pipe_q  <= '0;
      rgb_q       <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b0;
      for (int i = 0; i < PAL_DEPTH; i++) pal_q[i] <= '1;
      pal_q[0]    <= '0;
    end else begin
      font_addr_q <= font_addr_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      vld_pipe_q  <= vld_pipe_d;
      rgb_q       <= rgb_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      pal_q       <= pal_d;
    end
  end

  assign bus.font_addr = font_addr_q;
  assign bus.Red       = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign bus.Green     = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign bus.Blue      = rgb_q[COLOR_W-1:0];
  assign bus.vde_out   = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Bench for text_pixel_pipeline: directed cases with literal expectations plus random traffic
// checked every cycle against a behavioural model (BLINK_FRAMES=2).
module tb_text_pixel_pipeline;
  localparam int BF  = 2;
  localparam int LOG = 8192;
  localparam logic [12:0] W = 13'h1FFF;
  localparam logic [12:0] K = 13'h1000;
  localparam logic [12:0] Z = 13'h0000;
`ifdef TEXT_PIXEL_CURSOR_EN
  localparam logic [12:0] CUR_ON = W;
`else
  localparam logic [12:0] CUR_ON = K;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] g;
    logic [3:0] fg;
    logic [3:0] bg;
    logic       bl;
    logic       v;
    logic [6:0] cc;
    logic [5:0] cr;
  } rec_t;

  logic pixel_clk = 1'b0;
  logic reset = 1'b1;
  always #5 pixel_clk = ~pixel_clk;

  text_pixel_pipeline_if #(.COLOR_W(4), .PAL_DEPTH(16), .GLYPH_W(8), .FONT_H(16)) bus ();

  text_pixel_pipeline #(
    .COLOR_W(4), .PAL_DEPTH(16), .GLYPH_W(8), .FONT_H(16), .BLINK_FRAMES(BF)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0]  rom [0:2047];
  logic [11:0] pal [0:15];
  int          frames;
  rec_t        p1, p2;
  logic [12:0] exp_q;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        lit_on  [0:LOG-1];
  logic [12:0] lit_val [0:LOG-1];
  int          lit_id  [0:LOG-1];

  always @(posedge pixel_clk) bus.font_data <= rom[bus.font_addr];
  always @(posedge pixel_clk) cyc <= cyc + 1;

  function automatic rec_t cur_rec();
    rec_t r;
    r.x = bus.DrawX; r.y = bus.DrawY; r.g = bus.glyph; r.fg = bus.fg_idx; r.bg = bus.bg_idx;
    r.bl = bus.blink; r.v = bus.vde; r.cc = bus.cursor_col; r.cr = bus.cursor_row;
    return r;
  endfunction

  function automatic logic [11:0] model_rgb(rec_t r, int fr);
    int row;
    int sh;
    logic [7:0] bits;
    logic on;
    logic phase;
    if (!r.v) return 12'h000;
    phase = ((fr / BF) % 2) == 1;
    row   = int'(r.y) % 16;
    bits  = rom[int'(r.g[6:0]) * 16 + row];
    sh    = 7 - (int'(r.x) % 8);
    bits  = bits >> sh;
    on    = bits[0] ^ r.g[7];
    if (r.bl && phase) on = 1'b0;
`ifdef TEXT_PIXEL_CURSOR_EN
    if ((int'(r.x) / 8 == int'(r.cc)) && (int'(r.y) / 16 == int'(r.cr)) && (row >= 14) && !phase)
      on = ~on;
`endif
    return on ? pal[r.fg] : pal[r.bg];
  endfunction

  // reference: what leaves the pipe now was presented two edges ago, coloured with
  // the palette and blink phase in force just before this edge
  always @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      p1 <= '0;
      p2 <= '0;
      exp_q <= '0;
      frames <= 0;
      for (int i = 0; i < 16; i++) pal[i] <= (i == 0) ? 12'h000 : 12'hFFF;
    end else begin
      exp_q <= {p2.v, model_rgb(p2, frames)};
      p2 <= p1;
      p1 <= cur_rec();
      if (bus.pal_we) pal[bus.pal_waddr] <= bus.pal_wdata;
      if (bus.frame_start) frames <= frames + 1;
    end
  end

  function automatic string lname(int id);
    case (id)
      0: return "reset_state";   1: return "first_vde";    2: return "bit_order";
      3: return "invert";        4: return "vde_off";      5: return "pal_old";
      6: return "pal_new";       7: return "midline_reset"; 8: return "pal_reset";
      9: return "blink_cell";    10: return "steady_cell"; 11: return "cursor_ph0";
      12: return "cursor_row29"; 13: return "cursor_ph1";  14: return "pal5_white";
      15: return "pal0_black";   default: return "lit";
    endcase
  endfunction

  initial begin
    logic [12:0] got;
    forever begin
      @(negedge pixel_clk);
      got = {bus.vde_out, bus.Red, bus.Green, bus.Blue};
      total++;
      if (got !== exp_q) begin
        bad++;
        $display("FAIL model cyc=%0d got=%h want=%h", cyc, got, exp_q);
      end
      if (cyc < LOG && lit_on[cyc]) begin
        total++;
        if (got !== lit_val[cyc]) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h", lname(lit_id[cyc]), cyc, got, lit_val[cyc]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic expect_at(input int c, input logic [12:0] v, input int id);
    if (c < LOG) begin
      lit_on[c] = 1'b1; lit_val[c] = v; lit_id[c] = id;
    end
  endtask

  task automatic pix(input int x, input int y, input int g, input int fg, input int bg,
                     input int bl, input int v);
    bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.glyph = 8'(g);
    bus.fg_idx = 4'(fg); bus.bg_idx = 4'(bg); bus.blink = bl[0]; bus.vde = v[0];
    @(negedge pixel_clk);
  endtask

  task automatic idle(input int n);
    bus.vde = 1'b0; bus.blink = 1'b0;
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    @(negedge pixel_clk);
    bus.frame_start = 1'b0;
  endtask

  initial begin
    int c;
    for (int i = 0; i < LOG; i++) begin lit_on[i] = 1'b0; lit_val[i] = '0; lit_id[i] = 0; end
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom['h41 * 16 + 3] = 8'b1000_0000;
    for (int r = 0; r < 16; r++) rom['h20 * 16 + r] = 8'h00;
    bus.DrawX = '0; bus.DrawY = '0; bus.vde = 1'b0; bus.frame_start = 1'b0; bus.glyph = '0;
    bus.fg_idx = '0; bus.bg_idx = '0; bus.blink = 1'b0; bus.pal_we = 1'b0; bus.pal_waddr = '0;
    bus.pal_wdata = '0; bus.cursor_col = 7'd100; bus.cursor_row = 6'd60;
    expect_at(1, Z, 0);
    expect_at(2, Z, 0);
    repeat (3) @(negedge pixel_clk);
    reset = 1'b0;
    idle(2);

    // first valid output and default palette entries 5 and 0
    c = cyc;
    pix(0, 3, 'h41, 5, 0, 0, 1);
    pix(1, 3, 'h41, 5, 0, 0, 1);
    idle(4);
    expect_at(c + 2, Z, 1); expect_at(c + 3, W, 14); expect_at(c + 4, K, 15);

    // bit order, then inverted glyph, then vde low
    c = cyc;
    for (int i = 0; i < 8; i++) pix(i, 3, 'h41, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) pix(i, 3, 'hC1, 1, 0, 0, 1);
    pix(0, 3, 'h41, 1, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 8; i++) begin
      expect_at(c + 3 + i, (i == 0) ? W : K, 2);
      expect_at(c + 11 + i, (i == 0) ? K : W, 3);
    end
    expect_at(c + 19, Z, 4);

    // palette write lands on the same edge as a lookup of that entry
    c = cyc;
    pix(0, 3, 'h41, 3, 0, 0, 1);
    pix(0, 3, 'h41, 3, 0, 0, 1);
    bus.pal_we = 1'b1; bus.pal_waddr = 4'd3; bus.pal_wdata = 12'hF00;
    idle(1);
    bus.pal_we = 1'b0;
    idle(4);
    expect_at(c + 3, W, 5); expect_at(c + 4, 13'h1F00, 6);

    // asynchronous reset in the middle of a run of lit pixels
    pix(0, 3, 'h41, 1, 0, 0, 1);
    pix(0, 3, 'h41, 1, 0, 0, 1);
    pix(0, 3, 'h41, 1, 0, 0, 1);
    @(posedge pixel_clk);
    #2;
    reset = 1'b1;
    c = cyc;
    expect_at(c, Z, 7);
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    reset = 1'b0;
    idle(2);
    c = cyc;
    pix(0, 3, 'h41, 3, 0, 0, 1);
    idle(4);
    expect_at(c + 3, W, 8);

    // blink: frames 0-1 shown, 2-3 hidden, 4 shown again
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) frame_pulse();
      idle(4);
      c = cyc;
      pix(0, 3, 'h41, 1, 0, 1, 1);
      pix(0, 3, 'h41, 1, 0, 0, 1);
      idle(3);
      expect_at(c + 3, (k == 2 || k == 3) ? K : W, 9);
      expect_at(c + 4, W, 10);
    end

    // cursor on the bottom rows of cell (2,1), blink phase 0 then 1
    bus.cursor_col = 7'd2; bus.cursor_row = 6'd1;
    c = cyc;
    for (int i = 0; i < 8; i++) pix(16 + i, 30, 'h20, 1, 0, 0, 1);
    pix(16, 29, 'h20, 1, 0, 0, 1);
    pix(24, 30, 'h20, 1, 0, 0, 1);
    idle(4);
    for (int i = 0; i < 8; i++) expect_at(c + 3 + i, CUR_ON, 11);
    expect_at(c + 11, K, 12); expect_at(c + 12, K, 12);
    frame_pulse();
    frame_pulse();
    idle(3);
    c = cyc;
    for (int i = 0; i < 8; i++) pix(16 + i, 30, 'h20, 1, 0, 0, 1);
    idle(4);
    for (int i = 0; i < 8; i++) expect_at(c + 3 + i, K, 13);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int x, y;
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
      bus.frame_start = ($urandom_range(0, 23) == 0);
      bus.pal_we = ($urandom_range(0, 15) == 0);
      bus.pal_waddr = 4'($urandom);
      bus.pal_wdata = 12'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        bus.cursor_col = 7'(x >> 3); bus.cursor_row = 6'(y >> 4);
      end else begin
        bus.cursor_col = 7'($urandom); bus.cursor_row = 6'($urandom);
      end
      if (n == 1500) begin
        @(posedge pixel_clk);
        #3;
        reset = 1'b1;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        reset = 1'b0;
      end
      pix(x, y, $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 1), ($urandom_range(0, 4) != 0));
    end
    bus.frame_start = 1'b0;
    bus.pal_we = 1'b0;
    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
